// File: rtl/shazam_peak_picker.sv
// Shazam-style spectral peak picker.
// Follows the per-bin magnitude stream of each FFT frame. For each of six
// logarithmic bands in bins 0..LAST_BIN it tracks the strongest bin. Band peaks
// that reach MIN_MAGNITUDE are queued in a small FIFO for the hashing stage.
module shazam_peak_picker #(
    parameter int unsigned EDGE_1        = 10,
    parameter int unsigned EDGE_2        = 20,
    parameter int unsigned EDGE_3        = 40,
    parameter int unsigned EDGE_4        = 80,
    parameter int unsigned EDGE_5        = 160,
    parameter int unsigned LAST_BIN      = 511,
    parameter int unsigned MIN_MAGNITUDE = 64,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] magnitude_in,
    input  logic        magnitude_valid,
    input  logic [10:0] bin_index,
    output logic        peak_valid,
    input  logic        peak_ready,
    output logic [10:0] peak_bin,
    output logic [15:0] peak_magnitude,
    output logic [2:0]  peak_band,
    output logic [15:0] peak_frame,
    output logic        frame_done,
    output logic        frame_error,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [10:0] L_E1   = 11'(EDGE_1);
    localparam logic [10:0] L_E2   = 11'(EDGE_2);
    localparam logic [10:0] L_E3   = 11'(EDGE_3);
    localparam logic [10:0] L_E4   = 11'(EDGE_4);
    localparam logic [10:0] L_E5   = 11'(EDGE_5);
    localparam logic [10:0] L_LAST = 11'(LAST_BIN);
    localparam logic [15:0] L_MIN  = 16'(MIN_MAGNITUDE);
    localparam logic [AW:0] L_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SYNC, TRACK, SKIP} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [10:0] r_expected;
    logic [15:0] r_frameCount;
    logic        r_seenFirstFrame;

    logic [15:0] r_bandMax;
    logic [10:0] r_bandBin;

    logic        r_pushValid;
    logic [10:0] r_pushBin;
    logic [15:0] r_pushMag;
    logic [2:0]  r_pushBand;
    logic [15:0] r_pushFrame;
    logic        r_frameDone;
    logic        r_frameError;

    logic [10:0] r_fifoBin   [FIFO_DEPTH];
    logic [15:0] r_fifoMag   [FIFO_DEPTH];
    logic [2:0]  r_fifoBand  [FIFO_DEPTH];
    logic [15:0] r_fifoFrame [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic        w_binIsZero;
    logic        w_inMirror;
    logic        w_process;
    logic        w_error;
    logic [2:0]  w_band;
    logic        w_isFirst;
    logic        w_isLast;
    logic [15:0] w_candMax;
    logic [10:0] w_candBin;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign w_binIsZero = (bin_index == 11'd0);
    assign w_inMirror  = (bin_index > L_LAST) && (bin_index <= 11'd1023);

    // Band membership of the incoming bin and whether it opens or closes its band
    always_comb begin
        w_band = 3'd5;
        if (bin_index < L_E1)      w_band = 3'd0;
        else if (bin_index < L_E2) w_band = 3'd1;
        else if (bin_index < L_E3) w_band = 3'd2;
        else if (bin_index < L_E4) w_band = 3'd3;
        else if (bin_index < L_E5) w_band = 3'd4;
        w_isFirst = w_binIsZero || (bin_index == L_E1) || (bin_index == L_E2) ||
                    (bin_index == L_E3) || (bin_index == L_E4) || (bin_index == L_E5);
        w_isLast  = (bin_index == L_E1 - 11'd1) || (bin_index == L_E2 - 11'd1) ||
                    (bin_index == L_E3 - 11'd1) || (bin_index == L_E4 - 11'd1) ||
                    (bin_index == L_E5 - 11'd1) || (bin_index == L_LAST);
    end

    // Frame-alignment state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SYNC;
        else       r_state <= w_nextState;
    end

    // Frame-alignment next state: bin 0 always (re)starts a frame, anything out of order drops to SYNC
    always_comb begin
        w_nextState = r_state;
        if (magnitude_valid) begin
            case (r_state)
                SYNC:    if (w_binIsZero) w_nextState = TRACK;
                TRACK: begin
                    if (bin_index == r_expected)
                        w_nextState = (bin_index == L_LAST) ? SKIP : TRACK;
                    else if (w_binIsZero)
                        w_nextState = TRACK;
                    else
                        w_nextState = SYNC;
                end
                SKIP: begin
                    if (w_binIsZero)      w_nextState = TRACK;
                    else if (!w_inMirror) w_nextState = SYNC;
                end
                default: w_nextState = SYNC;
            endcase
        end
    end

    // Frame-alignment outputs: which bins feed band tracking and which raise a sequence error
    always_comb begin
        w_process = 1'b0;
        w_error   = 1'b0;
        if (magnitude_valid) begin
            case (r_state)
                SYNC: w_process = w_binIsZero;
                TRACK: begin
                    if (bin_index == r_expected) begin
                        w_process = 1'b1;
                    end else begin
                        w_error   = 1'b1;
                        w_process = w_binIsZero;
                    end
                end
                SKIP: begin
                    if (w_binIsZero)      w_process = 1'b1;
                    else if (!w_inMirror) w_error   = 1'b1;
                end
                default: begin
                    w_process = 1'b0;
                    w_error   = 1'b0;
                end
            endcase
        end
    end

    // Expected next bin and the frame counter, which skips the very first frame after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected       <= 11'd0;
            r_frameCount     <= 16'd0;
            r_seenFirstFrame <= 1'b0;
        end else begin
            if (w_process) r_expected <= bin_index + 11'd1;
            if (magnitude_valid && w_binIsZero) begin
                if (r_seenFirstFrame) r_frameCount <= r_frameCount + 16'd1;
                r_seenFirstFrame <= 1'b1;
            end
        end
    end

    // Running maximum of the current band; a strict compare keeps the lowest bin on ties
    always_comb begin
        w_candMax = r_bandMax;
        w_candBin = r_bandBin;
        if (w_isFirst || (magnitude_in > r_bandMax)) begin
            w_candMax = magnitude_in;
            w_candBin = bin_index;
        end
    end

    // Band tracker registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bandMax <= 16'd0;
            r_bandBin <= 11'd0;
        end else if (w_process) begin
            r_bandMax <= w_candMax;
            r_bandBin <= w_candBin;
        end
    end

    // Commit slot: one cycle after a band's last bin, carrying the peak and the status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pushValid  <= 1'b0;
            r_pushBin    <= 11'd0;
            r_pushMag    <= 16'd0;
            r_pushBand   <= 3'd0;
            r_pushFrame  <= 16'd0;
            r_frameDone  <= 1'b0;
            r_frameError <= 1'b0;
        end else begin
            r_pushValid  <= w_process && w_isLast && (w_candMax >= L_MIN);
            r_frameDone  <= w_process && (bin_index == L_LAST);
            r_frameError <= w_error;
            if (w_process && w_isLast) begin
                r_pushBin   <= w_candBin;
                r_pushMag   <= w_candMax;
                r_pushBand  <= w_band;
                r_pushFrame <= r_frameCount;
            end
        end
    end

    assign w_full = (r_count == L_FULL);
    assign w_pop  = (r_count != '0) && peak_ready;
    assign w_push = r_pushValid && (!w_full || w_pop);

    // Peak FIFO: when full, a push only lands if the head leaves in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifoBin[i]   <= 11'd0;
                r_fifoMag[i]   <= 16'd0;
                r_fifoBand[i]  <= 3'd0;
                r_fifoFrame[i] <= 16'd0;
            end
        end else begin
            if (w_push) begin
                r_fifoBin[r_wrPtr]   <= r_pushBin;
                r_fifoMag[r_wrPtr]   <= r_pushMag;
                r_fifoBand[r_wrPtr]  <= r_pushBand;
                r_fifoFrame[r_wrPtr] <= r_pushFrame;
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign peak_valid     = (r_count != '0);
    assign peak_bin       = r_fifoBin[r_rdPtr];
    assign peak_magnitude = r_fifoMag[r_rdPtr];
    assign peak_band      = r_fifoBand[r_rdPtr];
    assign peak_frame     = r_fifoFrame[r_rdPtr];
    assign frame_done     = r_frameDone;
    assign frame_error    = r_frameError;
    assign overflow       = r_pushValid && w_full && !w_pop;

endmodule
